// File: rtl/simd_shift_stage.sv
// Two-stage valid/ready wrapper around an external combinational SIMD shifter.
// S1 registers the operands that drive the shifter; S2 captures its result for downstream.
module simd_shift_stage #(
    parameter int unsigned SIMD_WIDTH = 256,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Upstream operation handshake
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD_WIDTH-1:0] in_a,
    input  logic [SIMD_WIDTH-1:0] in_b,
    input  logic [2:0]            in_data_mode,
    input  logic [1:0]            in_sel,
    input  logic                  in_imm_flag,
    input  logic [7:0]            in_imm_reg,
    input  logic                  flush,

    // Registered operands to the shifter and its combinational result
    output logic [SIMD_WIDTH-1:0] sh_a,
    output logic [SIMD_WIDTH-1:0] sh_b,
    output logic [2:0]            sh_data_mode,
    output logic [1:0]            sh_sel,
    output logic                  sh_imm_flag,
    output logic [7:0]            sh_imm_reg,
    input  logic [SIMD_WIDTH-1:0] sh_out,

    // Downstream result handshake
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] out_data,

    // Status
    output logic                  nop_seen,
    output logic [CNT_WIDTH-1:0]  op_count
);

    localparam logic [1:0] SelNop = 2'b10;

    // S1: operand stage
    logic                  s1_valid_q, s1_valid_d;
    logic [SIMD_WIDTH-1:0] s1_a_q;
    logic [SIMD_WIDTH-1:0] s1_b_q;
    logic [2:0]            s1_data_mode_q;
    logic [1:0]            s1_sel_q;
    logic                  s1_imm_flag_q;
    logic [7:0]            s1_imm_reg_q;

    // S2: result stage
    logic                  s2_valid_q, s2_valid_d;
    logic [SIMD_WIDTH-1:0] s2_data_q;

    logic                  nop_seen_q, nop_seen_d;
    logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

    logic                  accept;
    logic                  advance;
    logic                  consume;
    logic                  load_s2;

    // in_ready depends only on state, flush and out_ready, never on in_valid.
    always_comb begin
        advance  = s1_valid_q & (~s2_valid_q | out_ready);
        consume  = s2_valid_q & out_ready;
        in_ready = ~flush & (~s1_valid_q | advance);
        accept   = in_valid & in_ready;
        load_s2  = advance & ~flush;

        s1_valid_d = s1_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s2_valid_d = 1'b1;
        end else if (consume) begin
            s2_valid_d = 1'b0;
        end

        // A consume in a flush cycle still reached downstream, so it is counted.
        op_count_d = consume ? op_count_q + CNT_WIDTH'(1) : op_count_q;
        nop_seen_d = nop_seen_q | (accept & (in_sel == SelNop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_data_mode_q <= '0;
            s1_sel_q       <= '0;
            s1_imm_flag_q  <= 1'b0;
            s1_imm_reg_q   <= '0;
            s2_valid_q     <= 1'b0;
            s2_data_q      <= '0;
            nop_seen_q     <= 1'b0;
            op_count_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            nop_seen_q <= nop_seen_d;
            op_count_q <= op_count_d;
            if (accept) begin
                s1_a_q         <= in_a;
                s1_b_q         <= in_b;
                s1_data_mode_q <= in_data_mode;
                s1_sel_q       <= in_sel;
                s1_imm_flag_q  <= in_imm_flag;
                s1_imm_reg_q   <= in_imm_reg;
            end
            if (load_s2) begin
                s2_data_q <= sh_out;
            end
        end
    end

    assign sh_a         = s1_a_q;
    assign sh_b         = s1_b_q;
    assign sh_data_mode = s1_data_mode_q;
    assign sh_sel       = s1_sel_q;
    assign sh_imm_flag  = s1_imm_flag_q;
    assign sh_imm_reg   = s1_imm_reg_q;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign nop_seen  = nop_seen_q;
    assign op_count  = op_count_q;

endmodule
